// File: rtl/anton_apb_initiator_pkg.sv
// Shared types and constants for the APB initiator.
package anton_apb_initiator_pkg;

    // Bus phase of the initiator; encodings are fixed so other blocks can decode them.
    typedef enum logic [1:0] {
        APB_INIT_IDLE   = 2'd0,
        APB_INIT_SETUP  = 2'd1,
        APB_INIT_ACCESS = 2'd2
    } apbInitState_t;

    localparam int APB_TIMEOUT_DEFAULT = 255;

    // Wait counter must hold the value timeoutCycles itself; never narrower than 1 bit.
    function automatic int waitCntWidth(input int timeoutCycles);
        return (timeoutCycles < 2) ? 1 : $clog2(timeoutCycles + 1);
    endfunction

endpackage

// File: rtl/anton_apb_timeout.sv
// Wait-state counter for the APB initiator: cleared when a transfer is set up,
// incremented on every ACCESS cycle without apbPready, flags when LIMIT is reached.
module anton_apb_timeout #(
    parameter int LIMIT     = 255,
    parameter int CNT_WIDTH = 8
) (
    input  logic apbPclk,
    input  logic apbPresern,
    input  logic cntClr,
    input  logic cntInc,
    output logic expired
);

    logic [CNT_WIDTH-1:0] waitCnt;

    // Wait counter: clear has priority over increment.
    always_ff @(posedge apbPclk or negedge apbPresern) begin
        if (!apbPresern) begin
            waitCnt <= '0;
        end else if (cntClr) begin
            waitCnt <= '0;
        end else if (cntInc) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

    assign expired = (waitCnt == CNT_WIDTH'(LIMIT));

endmodule

// File: rtl/anton_apb_initiator.sv
// APB3 initiator: one valid/ready request becomes one APB transfer, with wait
// states, PSLVERR capture and an optional stuck-transfer timeout.
//
// state           | meaning
// ----------------+----------------------------------------------
// APB_INIT_IDLE   | no transfer, request accepted when reqValid
// APB_INIT_SETUP  | PSEL high, address/control on the bus
// APB_INIT_ACCESS | PSEL+PENABLE high, waiting for apbPready
module anton_apb_initiator
    import anton_apb_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
    input  logic                  apbPclk,
    input  logic                  apbPresern,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [ADDR_WIDTH-1:0] reqAddr,
    input  logic [DATA_WIDTH-1:0] reqWData,
    output logic                  rspValid,
    output logic [DATA_WIDTH-1:0] rspRData,
    output logic                  rspError,
    output logic                  rspTimeout,
    output logic                  apbPselx,
    output logic                  apbPenable,
    output logic                  apbPwrite,
    output logic [ADDR_WIDTH-1:0] apbPaddr,
    output logic [DATA_WIDTH-1:0] apbPwData,
    input  logic [DATA_WIDTH-1:0] apbPrData,
    input  logic                  apbPready,
    input  logic                  apbPslverr
);

    apbInitState_t state, nextState;
    logic accept, complete, abort, cntClr, cntInc, timeoutHit;

    assign reqReady = (state == APB_INIT_IDLE);

    // State register.
    always_ff @(posedge apbPclk or negedge apbPresern) begin
        if (!apbPresern) begin
            state <= APB_INIT_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode; apbPready wins over the timeout in the same cycle.
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        complete  = 1'b0;
        abort     = 1'b0;
        cntClr    = 1'b0;
        cntInc    = 1'b0;
        unique case (state)
            APB_INIT_IDLE: begin
                if (reqValid) begin
                    nextState = APB_INIT_SETUP;
                    accept    = 1'b1;
                    cntClr    = 1'b1;
                end
            end
            APB_INIT_SETUP: begin
                nextState = APB_INIT_ACCESS;
            end
            APB_INIT_ACCESS: begin
                if (apbPready) begin
                    nextState = APB_INIT_IDLE;
                    complete  = 1'b1;
                end else if (timeoutHit) begin
                    nextState = APB_INIT_IDLE;
                    abort     = 1'b1;
                end else begin
                    cntInc = 1'b1;
                end
            end
            default: begin
                nextState = APB_INIT_IDLE;
            end
        endcase
    end

    generate
        if (TIMEOUT_CYCLES != 0) begin : gTimeout
            anton_apb_timeout #(
                .LIMIT    (TIMEOUT_CYCLES),
                .CNT_WIDTH(waitCntWidth(TIMEOUT_CYCLES))
            ) uTimeout (
                .apbPclk   (apbPclk),
                .apbPresern(apbPresern),
                .cntClr    (cntClr),
                .cntInc    (cntInc),
                .expired   (timeoutHit)
            );
        end else begin : gNoTimeout
            logic unusedCntCtrl;
            assign unusedCntCtrl = cntClr ^ cntInc;
            assign timeoutHit    = 1'b0;
        end
    endgenerate

    // Registered bus outputs and response; bus fields hold their last value in IDLE.
    always_ff @(posedge apbPclk or negedge apbPresern) begin
        if (!apbPresern) begin
            apbPselx   <= 1'b0;
            apbPenable <= 1'b0;
            apbPwrite  <= 1'b0;
            apbPaddr   <= '0;
            apbPwData  <= '0;
            rspValid   <= 1'b0;
            rspRData   <= '0;
            rspError   <= 1'b0;
            rspTimeout <= 1'b0;
        end else begin
            apbPselx   <= (nextState != APB_INIT_IDLE);
            apbPenable <= (nextState == APB_INIT_ACCESS);
            rspValid   <= complete | abort;
            if (accept) begin
                apbPwrite <= reqWrite;
                apbPaddr  <= reqAddr;
                apbPwData <= reqWData;
            end
            if (complete) begin
                rspRData   <= apbPwrite ? '0 : apbPrData;
                rspError   <= apbPslverr;
                rspTimeout <= 1'b0;
            end else if (abort) begin
                rspRData   <= '0;
                rspError   <= 1'b1;
                rspTimeout <= 1'b1;
            end
        end
    end

endmodule
